// File: rtl/tinychip_pkg.sv
// Shared encodings for the multicycle controller: instruction fields,
// opcodes for both instruction types and the FSM state type.
package tinychip_pkg;

  localparam int INSTR_W  = 9;
  localparam int TYPE_BIT = 8;
  localparam int OP_HI    = 7;
  localparam int OP_LO    = 5;
  localparam int RD_HI    = 4;
  localparam int RD_LO    = 3;
  localparam int RO_HI    = 2;
  localparam int RO_LO    = 1;
  localparam int FN_BIT   = 0;
  localparam int IMM_W    = 3;

  // R-type (type bit = 0)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  // I-type (type bit = 1)
  localparam logic [2:0] OPI_ADDI = 3'b000;
  localparam logic [2:0] OPI_ANDI = 3'b001;
  localparam logic [2:0] OPI_BEQ  = 3'b010;
  localparam logic [2:0] OPI_BNE  = 3'b011;
  localparam logic [2:0] OPI_LW   = 3'b100;
  localparam logic [2:0] OPI_SW   = 3'b101;
  localparam logic [2:0] OPI_SRL  = 3'b110;
  localparam logic [2:0] OPI_SLTI = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational execute unit: one result per opcode/type plus an equality
// flag used for branch decisions.
module exec_alu
  import tinychip_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_type,
  input  logic [2:0]        i_opcode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_eq
);

  logic [2:0] w_shamt;
  logic       w_lt;
  logic       w_sh_oob;

  always_comb begin
    w_shamt  = i_b[2:0];
    w_sh_oob = (32'(w_shamt) >= DATA_W);
    w_lt     = ($signed(i_a) < $signed(i_b));
    o_eq     = (i_a == i_b);
    o_result = '0;
    if (!i_type) begin
      case (i_opcode)
        OP_ADD:  o_result = i_a + i_b;
        OP_AND:  o_result = i_a & i_b;
        OP_SUB:  o_result = i_a - i_b;
        OP_OR:   o_result = i_a | i_b;
        OP_XOR:  o_result = i_a ^ i_b;
        OP_SLT:  o_result = DATA_W'(w_lt);
        OP_SLL:  o_result = w_sh_oob ? '0 : (i_a << w_shamt);
        default: o_result = '0;
      endcase
    end else begin
      case (i_opcode)
        OPI_ADDI: o_result = i_a + i_b;
        OPI_ANDI: o_result = i_a & i_b;
        OPI_BEQ:  o_result = DATA_W'(o_eq);
        OPI_BNE:  o_result = DATA_W'(!o_eq);
        OPI_SRL:  o_result = w_sh_oob ? '0 : (i_a >> w_shamt);
        OPI_SLTI: o_result = DATA_W'(w_lt);
        default:  o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle 9-bit-instruction core: FETCH/EXEC/MEM/HALT FSM with a
// 4-entry register file, program counter and a req/ack data-memory port.
module multicycle_controller
  import tinychip_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int PC_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [DATA_W-1:0]  output_data,
  output logic               out_valid,
  output logic               halted,
  output state_t             dbg_state
);

  // Handshakes: an instruction transfers on a cycle with instr_valid &&
  // instr_ready; mem_req with its address/we/wdata stays asserted and
  // unchanged until the cycle mem_ack is seen, which completes the access.

  state_t              r_state, w_next_state;
  logic [PC_W-1:0]     r_pc, w_next_pc, w_pc_inc, w_pc_inc2, w_jmp_pc;
  logic [DATA_W-1:0]   r_regs [0:NUM_REGS-1];
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_out_data, r_mem_addr, r_mem_wdata;
  logic                r_out_valid, r_mem_we;

  logic                w_type, w_fn;
  logic [2:0]          w_op;
  logic [1:0]          w_rd, w_ro;
  logic [DATA_W-1:0]   w_a, w_b_reg, w_imm, w_b, w_alu_res, w_alu_eq_unused;
  logic                w_alu_eq;
  logic [DATA_W-1:0]   w_result, w_wr_data, w_mem_addr, w_mem_wdata;
  logic                w_retire, w_wr_en, w_mem_start, w_mem_we;

  assign w_type  = r_instr[TYPE_BIT];
  assign w_op    = r_instr[OP_HI:OP_LO];
  assign w_rd    = r_instr[RD_HI:RD_LO];
  assign w_ro    = r_instr[RO_HI:RO_LO];
  assign w_fn    = r_instr[FN_BIT];
  assign w_imm   = DATA_W'(r_instr[IMM_W-1:0]);
  assign w_a     = r_regs[w_rd];
  assign w_b_reg = r_regs[w_ro];
  assign w_b     = w_type ? w_imm : w_b_reg;

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_pc_inc2 = r_pc + PC_W'(2);
  assign w_jmp_pc  = PC_W'(w_a);
  assign w_alu_eq_unused = '0;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .i_type   (w_type),
    .i_opcode (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_alu_res),
    .o_eq     (w_alu_eq)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_retire     = 1'b0;
    w_result     = w_alu_res;
    w_wr_en      = 1'b0;
    w_wr_data    = w_alu_res;
    w_mem_start  = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = w_b_reg;
    w_mem_wdata  = w_b_reg;
    instr_ready  = (r_state == S_FETCH);
    mem_req      = (r_state == S_MEM);
    halted       = (r_state == S_HALT);
    case (r_state)
      S_FETCH: if (instr_valid) w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
        w_next_pc    = w_pc_inc;
        if (!w_type) begin
          if (w_op == OP_SYS) begin
            if (w_fn) begin
              w_next_pc = w_jmp_pc;
              w_result  = DATA_W'(w_jmp_pc);
            end else begin
              w_next_state = S_HALT;
              w_retire     = 1'b0;
              w_next_pc    = r_pc;
            end
          end else begin
            w_wr_en = 1'b1;
          end
        end else begin
          case (w_op)
            OPI_BEQ: if (w_alu_eq) w_next_pc = w_pc_inc2;
            OPI_BNE: if (!w_alu_eq) w_next_pc = w_pc_inc2;
            OPI_LW, OPI_SW: begin
              // Memory ops retire only when the access completes.
              w_next_state = S_MEM;
              w_retire     = 1'b0;
              w_next_pc    = r_pc;
              w_mem_start  = 1'b1;
              w_mem_we     = (w_op == OPI_SW);
              w_mem_addr   = (w_op == OPI_SW) ? w_a : w_b_reg;
            end
            default: w_wr_en = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
          w_next_pc    = w_pc_inc;
          if (r_mem_we) begin
            w_result = r_mem_wdata;
          end else begin
            w_result  = mem_rdata;
            w_wr_en   = 1'b1;
            w_wr_data = mem_rdata;
          end
        end
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_instr     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_out_valid <= w_retire;
      if (w_retire) r_out_data <= w_result;
      if (w_wr_en) r_regs[w_rd] <= w_wr_data;
      if (r_state == S_FETCH && instr_valid) r_instr <= instruction;
      if (w_mem_start) begin
        r_mem_we    <= w_mem_we;
        r_mem_addr  <= w_mem_addr;
        r_mem_wdata <= w_mem_wdata;
      end
    end
  end

  assign pc          = r_pc;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign output_data = r_out_data | w_alu_eq_unused;
  assign out_valid   = r_out_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: architectural model of the
// ISA, directed sequences with literal expectations, and random programs.
module tb_multicycle_controller;
  import tinychip_pkg::*;

  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic [PW-1:0] pc;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata, output_data;
  logic          out_valid, halted;
  state_t        dbg_state;

  multicycle_controller #(.DATA_W(DW), .NUM_REGS(4), .PC_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .output_data (output_data),
    .out_valid   (out_valid),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  int m_regs [4];
  int m_pc;
  int model_mem [256];
  int env_mem [256];
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] exp_pc_q [$];
  int e_is_mem, e_maddr, e_mwe, e_mwdata;

  function automatic int sx(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc = 0;
    exp_q.delete();
    exp_pc_q.delete();
  endtask

  task automatic model_step(input logic [8:0] ins);
    int t, op, rd, ro, fn, imm, a, b, res, npc, wr, msk, sh;
    msk = (1 << DW) - 1;
    t = ins[8]; op = ins[7:5]; rd = ins[4:3]; ro = ins[2:1]; fn = ins[0]; imm = ins[2:0];
    a = m_regs[rd]; b = m_regs[ro];
    res = 0; wr = 0; e_is_mem = 0;
    npc = (m_pc + 1) % (1 << PW);
    if (t == 0) begin
      wr = 1;
      sh = b % 8;
      case (op)
        0: res = (a + b) & msk;
        1: res = a & b;
        2: res = (a - b) & msk;
        3: res = a | b;
        4: res = a ^ b;
        5: res = (sx(a) < sx(b)) ? 1 : 0;
        6: res = (sh >= DW) ? 0 : ((a << sh) & msk);
        default: begin
          wr = 0;
          npc = a % (1 << PW);
          res = npc & msk;
        end
      endcase
    end else begin
      case (op)
        0: begin res = (a + imm) & msk; wr = 1; end
        1: begin res = a & imm; wr = 1; end
        2: begin res = (a == imm) ? 1 : 0; npc = (m_pc + (res ? 2 : 1)) % (1 << PW); end
        3: begin res = (a != imm) ? 1 : 0; npc = (m_pc + (res ? 2 : 1)) % (1 << PW); end
        4: begin
          e_is_mem = 1; e_mwe = 0; e_maddr = b;
          res = model_mem[b]; wr = 1;
        end
        5: begin
          e_is_mem = 1; e_mwe = 1; e_maddr = a; e_mwdata = b;
          model_mem[a] = b; res = b;
        end
        6: begin res = (imm >= DW) ? 0 : (a >> imm); wr = 1; end
        default: begin res = (sx(a) < imm) ? 1 : 0; wr = 1; end
      endcase
    end
    if (wr) m_regs[rd] = res;
    m_pc = npc;
    exp_q.push_back(DW'(res));
    exp_pc_q.push_back(PW'(npc));
  endtask

  // Every retirement pulse is matched against the next model expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        logic [DW-1:0] ed;
        logic [PW-1:0] ep;
        ed = exp_q.pop_front();
        ep = exp_pc_q.pop_front();
        check("retire_output_data", output_data, ed);
        check("retire_pc", pc, ep);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [8:0] r_ins(input int op, input int rd, input int ro, input int fn);
    return {1'b0, 3'(op), 2'(rd), 2'(ro), 1'(fn)};
  endfunction

  function automatic logic [8:0] i_ins(input int op, input int rd, input int imm);
    return {1'b1, 3'(op), 2'(rd), 3'(imm)};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issues one non-halt instruction, serves its memory access and returns
  // the cycles from the accepting edge to the visible out_valid pulse.
  task automatic issue(input logic [8:0] ins, input int wait_cyc, output int lat);
    int n, req_cycles, exp_lat;
    bit done, unstable;
    logic [DW-1:0] a0, d0;
    logic we0;
    model_step(ins);
    @(negedge clk);
    check("instr_ready_idle", instr_ready, 1);
    instruction = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instruction = 9'($urandom);
    instr_valid = 1'($urandom_range(0, 1));
    n = 0; done = 0; req_cycles = 0; unstable = 0; lat = -1;
    a0 = '0; d0 = '0; we0 = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      mem_ack = 1'b0;
      if (n >= 2) instr_valid = 1'b0;
      if (out_valid) begin
        lat = n;
        done = 1;
      end else if (mem_req) begin
        if (req_cycles == 0) begin
          a0 = mem_addr; we0 = mem_we; d0 = mem_wdata;
          check("mem_addr", mem_addr, e_maddr);
          check("mem_we", mem_we, e_mwe);
          if (e_mwe) check("mem_wdata", mem_wdata, e_mwdata);
        end else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== d0) begin
          unstable = 1;
        end
        req_cycles++;
        if (req_cycles > wait_cyc) begin
          mem_ack = 1'b1;
          if (mem_we) env_mem[mem_addr] = mem_wdata;
          mem_rdata = DW'(env_mem[mem_addr]);
        end else begin
          mem_rdata = DW'($urandom);
        end
      end
    end
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    if (!done) check("retire_timeout", 0, 1);
    exp_lat = e_is_mem ? 3 + wait_cyc : 2;
    check("latency", lat, exp_lat);
    if (e_is_mem) begin
      check("mem_req_cycles", req_cycles, wait_cyc + 1);
      check("mem_stable", unstable, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    logic [8:0] ins;
    reset = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom_range(0, 255);
      env_mem[i] = model_mem[i];
    end

    do_reset();
    check("rst_pc", pc, 0);
    check("rst_instr_ready", instr_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_output_data", output_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_halted", halted, 0);

    // addi r1,5
    issue(i_ins(0, 1, 5), 0, lat);
    check("lit_addi_data", output_data, 5);
    check("lit_addi_pc", pc, 1);
    check("lit_addi_latency", lat, 2);
    issue(i_ins(0, 2, 3), 0, lat);
    issue(r_ins(2, 1, 2, 0), 0, lat);
    check("lit_sub", output_data, 2);
    issue(i_ins(1, 1, 0), 0, lat);
    issue(i_ins(0, 1, 5), 0, lat);
    issue(r_ins(5, 2, 1, 0), 0, lat);
    check("lit_slt", output_data, 1);
    issue(i_ins(1, 2, 0), 0, lat);
    issue(i_ins(0, 2, 3), 0, lat);
    issue(r_ins(6, 1, 2, 0), 0, lat);
    check("lit_sll", output_data, 40);
    issue(i_ins(1, 1, 0), 0, lat);
    issue(i_ins(0, 1, 5), 0, lat);

    // branches from pc=4
    issue(i_ins(1, 3, 0), 0, lat);
    issue(i_ins(0, 3, 4), 0, lat);
    issue(r_ins(7, 3, 0, 1), 0, lat);
    check("lit_jump_pc", pc, 4);
    check("lit_jump_data", output_data, 4);
    issue(i_ins(2, 1, 5), 0, lat);
    check("lit_beq_pc", pc, 6);
    check("lit_beq_data", output_data, 1);
    issue(r_ins(7, 3, 0, 1), 0, lat);
    issue(i_ins(3, 1, 5), 0, lat);
    check("lit_bne_pc", pc, 5);
    check("lit_bne_data", output_data, 0);

    // taken beq at pc=255 wraps to 1
    issue(i_ins(1, 0, 0), 0, lat);
    issue(i_ins(1, 3, 0), 0, lat);
    issue(i_ins(0, 3, 1), 0, lat);
    issue(r_ins(2, 0, 3, 0), 0, lat);
    check("lit_r0_255", output_data, 255);
    issue(r_ins(7, 0, 0, 1), 0, lat);
    check("lit_pc_255", pc, 255);
    issue(i_ins(2, 1, 5), 0, lat);
    check("lit_beq_wrap_pc", pc, 1);

    // sw r1 -> [r3], ack on the third request cycle; then lw r2 <- [r3]
    issue(i_ins(5, 3, 2), 2, lat);
    check("lit_sw_latency", lat, 5);
    check("lit_sw_addr", mem_addr, 1);
    check("lit_sw_wdata", mem_wdata, 5);
    check("lit_sw_data", output_data, 5);
    issue(i_ins(4, 2, 6), 0, lat);
    check("lit_lw_latency", lat, 3);
    check("lit_lw_data", output_data, 5);
    issue(r_ins(3, 2, 2, 0), 0, lat);
    check("lit_r2_loaded", output_data, 5);

    // random programs (halt excluded)
    for (int k = 0; k < 300; k++) begin
      do begin
        ins = 9'($urandom_range(0, 511));
      end while (ins[8] == 1'b0 && ins[7:5] == 3'b111 && ins[0] == 1'b0);
      issue(ins, $urandom_range(0, 3), lat);
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    // reset during a pending load, then a late ack
    @(negedge clk);
    instruction = i_ins(4, 1, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_mem_req", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midmem_rst_mem_req", mem_req, 0);
    check("midmem_rst_pc", pc, 0);
    reset = 1'b0;
    model_reset();
    mem_ack = 1'b1;
    mem_rdata = 8'hA5;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_out_valid", out_valid, 0);
    check("late_ack_mem_req", mem_req, 0);
    check("late_ack_pc", pc, 0);
    for (int r = 0; r < 4; r++) begin
      issue(r_ins(3, r, r, 0), 0, lat);
      check("reg_cleared", output_data, 0);
    end

    // halt and ignored fetches
    @(negedge clk);
    instruction = r_ins(7, 0, 0, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("halt_halted", halted, 1);
    check("halt_instr_ready", instr_ready, 0);
    check("halt_dbg_state", dbg_state, S_HALT);
    for (int c = 0; c < 10; c++) begin
      instruction = i_ins(0, 1, 7);
      instr_valid = 1'b1;
      @(negedge clk);
      check("halt_stays", halted, 1);
      check("halt_pc_hold", pc, m_pc);
      check("halt_no_retire", out_valid, 0);
    end
    instr_valid = 1'b0;
    do_reset();
    @(negedge clk);
    check("halt_cleared", halted, 0);
    check("halt_cleared_ready", instr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
